// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg
//   Shared types and helpers for the APB memory slave (apb_mem_slave_p).
//   - state_t      : transfer FSM states IDLE / WAIT / DONE
//   - CNT_W        : width of the wait-state counter (WAIT_STATES <= 15)
//   - strb_width() : number of byte lanes for a given data width
//   - off_bits()   : number of byte-offset address bits inside one word
package apb_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CNT_W = 32'sd4;

   function automatic int strb_width(input int dw);
      return dw / 32'sd8;
   endfunction

   // Only 8/16/32-bit buses are legal; anything else is treated as byte-wide.
   function automatic int off_bits(input int dw);
      int r;
      case (dw)
         32'sd16: r = 32'sd1;
         32'sd32: r = 32'sd2;
         default: r = 32'sd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/apb_mem_slave_p_array.sv
// apb_mem_array
//   DEPTH x DATA_WIDTH word RAM, synchronous byte-enabled write, asynchronous
//   read. Contents are deliberately not reset.
//   Ports:
//     clk    in  clock
//     be     in  per-byte write enables (all zero = no write)
//     waddr  in  write word index
//     wdata  in  write data
//     raddr  in  read word index
//     rdata  out read data (combinational)
module apb_mem_array
   import apb_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int IW         = 6
) (
   input  logic                              clk,
   input  logic [strb_width(DATA_WIDTH)-1:0] be,
   input  logic [IW-1:0]                     waddr,
   input  logic [DATA_WIDTH-1:0]             wdata,
   input  logic [IW-1:0]                     raddr,
   output logic [DATA_WIDTH-1:0]             rdata
);

   localparam int SW     = strb_width(DATA_WIDTH);
   localparam int BYTE_W = 32'sd8;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Byte-lane write port.
   always_ff @(posedge clk) begin
      for (int b = 0; b < SW; b++) begin
         if (be[b]) begin
            mem_r[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
         end
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p
//   Parametrised APB4-style memory slave: word RAM with programmable wait
//   states, misalignment / out-of-range error response and (optionally)
//   byte-lane write strobes.
//   Optional feature macro: APB_MEM_SLAVE_PSTRB_EN (adds pstrb port).
//   Ports:
//     clk, resetn            clock, async active-low reset
//     psel, penable, pwrite  APB control
//     paddr                  byte address
//     pwdata                 write data
//     pstrb                  byte strobes (only with APB_MEM_SLAVE_PSTRB_EN)
//     prdata                 registered read data
//     pready                 registered transfer completion
//     pslverr                registered error response (only with pready)
module apb_mem_slave_p
   import apb_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              psel,
   input  logic                              penable,
   input  logic                              pwrite,
   input  logic [ADDR_WIDTH-1:0]             paddr,
   input  logic [DATA_WIDTH-1:0]             pwdata,
`ifdef APB_MEM_SLAVE_PSTRB_EN
   input  logic [strb_width(DATA_WIDTH)-1:0] pstrb,
`endif
   output logic [DATA_WIDTH-1:0]             prdata,
   output logic                              pready,
   output logic                              pslverr
);

   localparam int SW  = strb_width(DATA_WIDTH);
   localparam int OFF = off_bits(DATA_WIDTH);
   localparam int IW  = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((32'sd1 <<< OFF) - 32'sd1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_L  = DEPTH[ADDR_WIDTH:0];

   state_t                  state_r, state_nxt_s;
   logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic                    write_r, err_r;
   logic [DATA_WIDTH-1:0]   prdata_r;
   logic                    pready_r, pslverr_r;

   logic                    setup_s, wr_sel_s, err_s, enter_done_s, commit_s;
   logic [ADDR_WIDTH-1:0]   sel_addr_s, idx_s;
   logic [SW-1:0]           be_s;
   logic [DATA_WIDTH-1:0]   rdata_s;

   assign setup_s = (state_r == IDLE) && psel && !penable;

   // With zero wait states DONE is entered straight from setup, so the address
   // and direction must come from the bus in that cycle rather than the latch.
   assign sel_addr_s = setup_s ? paddr  : addr_r;
   assign wr_sel_s   = setup_s ? pwrite : write_r;
   assign idx_s      = sel_addr_s >> OFF;
   assign err_s      = ((sel_addr_s & OFF_MASK) != '0) || ({1'b0, idx_s} >= DEPTH_L);

   // Next-state and wait-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (setup_s) begin
               if (WAIT_STATES == 0) begin
                  state_nxt_s = DONE;
                  cnt_nxt_s   = '0;
               end else begin
                  state_nxt_s = WAIT;
                  cnt_nxt_s   = CNT_W'(WAIT_STATES);
               end
            end else begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = '0;
            end
         end
         WAIT: begin
            if (!psel) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = '0;
            end else if (cnt_r <= 4'd1) begin
               state_nxt_s = DONE;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = WAIT;
               cnt_nxt_s   = cnt_r - 4'd1;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   assign enter_done_s = (state_nxt_s == DONE);
   assign commit_s     = (state_r == DONE) && psel && penable && write_r && !err_r;

   // Byte enables for the RAM; only nonzero on the edge that ends a good write.
   always_comb begin
      be_s = '0;
`ifdef APB_MEM_SLAVE_PSTRB_EN
      if (commit_s) begin
         be_s = pstrb;
      end else begin
         be_s = '0;
      end
`else
      be_s = {SW{commit_s}};
`endif
   end

   // FSM state, transfer latch and registered APB outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         addr_r    <= '0;
         write_r   <= 1'b0;
         err_r     <= 1'b0;
         prdata_r  <= '0;
         pready_r  <= 1'b0;
         pslverr_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         pready_r  <= enter_done_s;
         pslverr_r <= enter_done_s && err_s;
         if (setup_s) begin
            addr_r  <= paddr;
            write_r <= pwrite;
            err_r   <= err_s;
         end
         if (enter_done_s && !wr_sel_s) begin
            prdata_r <= err_s ? '0 : rdata_s;
         end
      end
   end

   apb_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IW         (IW)
   ) u_array (
      .clk   (clk),
      .be    (be_s),
      .waddr (idx_s[IW-1:0]),
      .wdata (pwdata),
      .raddr (idx_s[IW-1:0]),
      .rdata (rdata_s)
   );

   assign prdata  = prdata_r;
   assign pready  = pready_r;
   assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// tb_apb_mem_slave_p
//   Directed bench for apb_mem_slave_p. Three instances with separate buses:
//     0: WAIT_STATES=0, DEPTH=48   1: WAIT_STATES=2, DEPTH=64
//     2: WAIT_STATES=3, DEPTH=64
//   Inputs are driven on the falling edge, outputs sampled there as well.
module tb_apb_mem_slave_p;

   logic        clk;
   logic        resetn;
   logic [2:0]  psel, penable, pwrite;
   logic [7:0]  paddr  [3];
   logic [31:0] pwdata [3];
   logic [3:0]  pstrb  [3];
   logic [31:0] prdata [3];
   logic [2:0]  pready, pslverr;

   int          n_chk;
   int          n_fail;
   logic [31:0] x_rd;
   logic        x_er;
   int          x_len;
   logic [15:0] x_hist;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   apb_mem_slave_p #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(48), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .resetn(resetn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
      .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_MEM_SLAVE_PSTRB_EN
      .pstrb(pstrb[0]),
`endif
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

   apb_mem_slave_p #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .resetn(resetn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
      .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_MEM_SLAVE_PSTRB_EN
      .pstrb(pstrb[1]),
`endif
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

   apb_mem_slave_p #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .resetn(resetn), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
      .paddr(paddr[2]), .pwdata(pwdata[2]),
`ifdef APB_MEM_SLAVE_PSTRB_EN
      .pstrb(pstrb[2]),
`endif
      .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

   // One full APB transfer on bus k, entered and left at a falling edge.
   // x_len counts the setup cycle plus access cycles up to and including pready.
   // x_hist[i] is pready in access cycle T(i+1).
   task automatic xfer(input int k, input logic wr, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] sb);
      bit got;
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
      paddr[k] = a; pwdata[k] = wd; pstrb[k] = sb;
      x_hist = '0; x_len = 1; x_rd = '0; x_er = 1'b0; got = 1'b0;
      @(posedge clk); @(negedge clk);
      penable[k] = 1'b1;
      for (int i = 0; i < 16 && !got; i++) begin
         x_len++;
         x_hist[i] = pready[k];
         if (pready[k]) begin
            x_rd = prdata[k]; x_er = pslverr[k]; got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL xfer_timeout: dut %0d addr %h pready never rose, required within 16 cycles", k, a);
      end
      @(posedge clk); @(negedge clk);
      psel[k] = 1'b0; penable[k] = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (pready[k] !== 1'b0) begin n_fail++; $display("FAIL reset_pready: dut %0d got %b expected 0", k, pready[k]); end
         n_chk++;
         if (pslverr[k] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: dut %0d got %b expected 0", k, pslverr[k]); end
         n_chk++;
         if (prdata[k] !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: dut %0d got %h expected 0", k, prdata[k]); end
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ws0_write_read;
      xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
      n_chk++;
      if (x_len !== 2) begin n_fail++; $display("FAIL ws0_wr_len: got %0d expected 2", x_len); end
      n_chk++;
      if (x_er !== 1'b0) begin n_fail++; $display("FAIL ws0_wr_err: got %b expected 0", x_er); end
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0);
      n_chk++;
      if (x_len !== 2) begin n_fail++; $display("FAIL ws0_rd_len: got %0d expected 2", x_len); end
      n_chk++;
      if (x_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ws0_rd_data: got %h expected deadbeef", x_rd); end
      n_chk++;
      if (x_er !== 1'b0) begin n_fail++; $display("FAIL ws0_rd_err: got %b expected 0", x_er); end
   endtask

   task automatic test_wait_states;
      xfer(1, 1'b1, 8'h04, 32'h0BADF00D, 4'hF);
      n_chk++;
      if (x_len !== 4) begin n_fail++; $display("FAIL ws2_wr_len: got %0d expected 4", x_len); end
      xfer(1, 1'b0, 8'h04, 32'h0, 4'h0);
      n_chk++;
      if (x_len !== 4) begin n_fail++; $display("FAIL ws2_rd_len: got %0d expected 4", x_len); end
      n_chk++;
      if (x_hist[2:0] !== 3'b100) begin n_fail++; $display("FAIL ws2_pready_seq: got %b expected 100", x_hist[2:0]); end
      n_chk++;
      if (x_rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL ws2_rd_data: got %h expected 0badf00d", x_rd); end
      n_chk++;
      if (x_er !== 1'b0) begin n_fail++; $display("FAIL ws2_rd_err: got %b expected 0", x_er); end
   endtask

   task automatic test_errors;
      xfer(0, 1'b1, 8'h00, 32'h13572468, 4'hF);
      xfer(0, 1'b1, 8'hBC, 32'h0000BC00, 4'hF);
      n_chk++;
      if (x_er !== 1'b0) begin n_fail++; $display("FAIL err_last_index: got %b expected 0", x_er); end
      xfer(0, 1'b1, 8'hC0, 32'h99999999, 4'hF);
      n_chk++;
      if (x_er !== 1'b1) begin n_fail++; $display("FAIL err_range_wr: got %b expected 1", x_er); end
      xfer(0, 1'b1, 8'h11, 32'h99999999, 4'hF);
      n_chk++;
      if (x_er !== 1'b1) begin n_fail++; $display("FAIL err_misalign_wr: got %b expected 1", x_er); end
      xfer(0, 1'b0, 8'h00, 32'h0, 4'h0);
      n_chk++;
      if (x_rd !== 32'h13572468) begin n_fail++; $display("FAIL err_rd0_data: got %h expected 13572468", x_rd); end
      n_chk++;
      if (x_er !== 1'b0) begin n_fail++; $display("FAIL err_rd0_err: got %b expected 0", x_er); end
      xfer(0, 1'b0, 8'hC0, 32'h0, 4'h0);
      n_chk++;
      if (x_rd !== 32'h0) begin n_fail++; $display("FAIL err_rdC0_data: got %h expected 0", x_rd); end
      n_chk++;
      if (x_er !== 1'b1) begin n_fail++; $display("FAIL err_rdC0_err: got %b expected 1", x_er); end
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0);
      n_chk++;
      if (x_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_misalign_nowrite: got %h expected deadbeef", x_rd); end
      xfer(0, 1'b0, 8'hBC, 32'h0, 4'h0);
      n_chk++;
      if (x_rd !== 32'h0000BC00) begin n_fail++; $display("FAIL err_last_rd: got %h expected 0000bc00", x_rd); end
   endtask

   task automatic test_protocol_violation;
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
      paddr[0] = 8'h00; pwdata[0] = 32'hFFFFFFFF; pstrb[0] = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if (pready[0] !== 1'b0) begin n_fail++; $display("FAIL proto_pready: cycle %0d got %b expected 0", i, pready[0]); end
      end
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(negedge clk);
      xfer(0, 1'b0, 8'h00, 32'h0, 4'h0);
      n_chk++;
      if (x_rd !== 32'h13572468) begin n_fail++; $display("FAIL proto_nowrite: got %h expected 13572468", x_rd); end
   endtask

   task automatic test_strobes;
      xfer(0, 1'b1, 8'h08, 32'h11223344, 4'hF);
      xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'b0101);
      xfer(0, 1'b0, 8'h08, 32'h0, 4'h0);
`ifdef APB_MEM_SLAVE_PSTRB_EN
      n_chk++;
      if (x_rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL strb_merge: got %h expected 11bb33dd", x_rd); end
      xfer(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'b0000);
      n_chk++;
      if (x_er !== 1'b0) begin n_fail++; $display("FAIL strb_zero_err: got %b expected 0", x_er); end
      xfer(0, 1'b0, 8'h08, 32'h0, 4'h0);
      n_chk++;
      if (x_rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL strb_zero_nochange: got %h expected 11bb33dd", x_rd); end
`else
      n_chk++;
      if (x_rd !== 32'hAABBCCDD) begin n_fail++; $display("FAIL full_word_write: got %h expected aabbccdd", x_rd); end
`endif
   endtask

   task automatic test_reset_midxfer;
      xfer(2, 1'b1, 8'h20, 32'h00000001, 4'hF);
      n_chk++;
      if (x_len !== 5) begin n_fail++; $display("FAIL ws3_wr_len: got %0d expected 5", x_len); end
      xfer(2, 1'b0, 8'h20, 32'h0, 4'h0);
      n_chk++;
      if (x_rd !== 32'h00000001) begin n_fail++; $display("FAIL ws3_pre_rd: got %h expected 00000001", x_rd); end
      // T0 setup, T1 access, reset asserted in T2
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
      paddr[2] = 8'h20; pwdata[2] = 32'hCAFEF00D; pstrb[2] = 4'hF;
      @(negedge clk);
      penable[2] = 1'b1;
      @(negedge clk);
      resetn = 1'b0;
      #1;
      n_chk++;
      if (prdata[2] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_prdata: got %h expected 0", prdata[2]); end
      n_chk++;
      if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pready: got %b expected 0", pready[2]); end
      n_chk++;
      if (pslverr[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pslverr: got %b expected 0", pslverr[2]); end
      @(negedge clk);
      psel[2] = 1'b0; penable[2] = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      xfer(2, 1'b0, 8'h20, 32'h0, 4'h0);
      n_chk++;
      if (x_rd !== 32'h00000001) begin n_fail++; $display("FAIL rst_mid_nowrite: got %h expected 00000001", x_rd); end
      n_chk++;
      if (x_len !== 5) begin n_fail++; $display("FAIL rst_mid_rd_len: got %0d expected 5", x_len); end
   endtask

   task automatic test_abort;
      xfer(1, 1'b1, 8'h0C, 32'h5A5A0001, 4'hF);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
      paddr[1] = 8'h0C; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF;
      @(negedge clk);
      psel[1] = 1'b0; penable[1] = 1'b0;
      n_chk++;
      if (pready[1] !== 1'b0) begin n_fail++; $display("FAIL abort_pready_t1: got %b expected 0", pready[1]); end
      @(negedge clk);
      n_chk++;
      if (pready[1] !== 1'b0) begin n_fail++; $display("FAIL abort_pready_t2: got %b expected 0", pready[1]); end
      // back-to-back setup right after the abort
      xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0);
      n_chk++;
      if (x_len !== 4) begin n_fail++; $display("FAIL abort_next_len: got %0d expected 4", x_len); end
      n_chk++;
      if (x_rd !== 32'h5A5A0001) begin n_fail++; $display("FAIL abort_nowrite: got %h expected 5a5a0001", x_rd); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      psel = '0; penable = '0; pwrite = '0;
      for (int k = 0; k < 3; k++) begin
         paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
      end
      resetn = 1'b0;
      @(negedge clk);
      test_reset();
      test_ws0_write_read();
      test_wait_states();
      test_errors();
      test_protocol_violation();
      test_strobes();
      test_reset_midxfer();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule
